cpu7_biu_arb: RTL and testbench
===============================

# cpu7_biu_arb

Single-outstanding arbiter that shares one 64-bit memory/bus port between the IFU fetch interface and the LSU. It sits between the IFU fetch datapath (req/ack/cancel/data_valid protocol) and the core's bus interface unit. It grants the port, routes responses back to the owner, and silently drains responses for fetches the IFU has cancelled. It gives the LSU priority, with a bounded-starvation guarantee for the IFU.

## Interface
- LSU_STARVE_MAX, default 3: maximum number of consecutive LSU grants made while the IFU is requesting; range 1..15.
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ifu_icu_req_ic1  in  1  IFU fetch request
- ifu_icu_addr_ic1  in  32  fetch address
- ifu_icu_cancel  in  1  cancel the outstanding fetch; may coincide with a new request
- icu_ifu_ack_ic1  out  1  fetch request accepted this cycle
- icu_ifu_data_ic2  out  64  fetch data
- icu_ifu_data_valid_ic2  out  1  fetch data valid, 1-cycle pulse
- lsu_req  in  1  LSU access request
- lsu_addr  in  32  byte address
- lsu_wr  in  1  1 = store, 0 = load
- lsu_wdata  in  32  store data
- lsu_wstrb  in  4  byte strobes
- lsu_ack  out  1  LSU request accepted this cycle
- lsu_rdata  out  32  load data, which is the 32-bit half of mem_rdata selected by the latched addr[2]
- lsu_data_valid  out  1  load data or store completion, 1-cycle pulse
- mem_req  out  1  downstream request
- mem_addr  out  32  downstream address (IFU addresses are passed through unmodified)
- mem_wr  out  1  downstream write
- mem_wdata  out  64  {lsu_wdata, lsu_wdata}
- mem_wstrb  out  8  lsu_wstrb placed at [7:4] if addr[2] = 1, else at [3:0]; 0 for IFU
- mem_ack  in  1  downstream accepted the request
- mem_rdata  in  64  response data
- mem_rvalid  in  1  response valid (for reads and writes)

## Operation
- States:
  - IDLE
  - IFU_BUSY
  - LSU_BUSY
  - DRAIN, which holds a cancelled IFU transaction whose response must be discarded.
- Arbitration happens only in IDLE and is combinational:
  - The winner is the LSU if lsu_req is asserted and NOT (ifu_icu_req_ic1 and starve_cnt == LSU_STARVE_MAX).
  - Otherwise the winner is the IFU if ifu_icu_req_ic1 is asserted.
- mem_req and the mem_addr/wr/wdata/wstrb fields are driven from the winner only in IDLE.
  - mem_req is 0 in every other state and while reset is asserted.
- Acceptance: when mem_ack is asserted in IDLE, the matching icu_ifu_ack_ic1 or lsu_ack is asserted in the same cycle, and the state moves to IFU_BUSY or LSU_BUSY.
  - If mem_ack is not asserted, the state stays in IDLE and arbitration is re-evaluated the next cycle. Requesters hold their requests until acked.
- LSU_BUSY:
  - On mem_rvalid: lsu_data_valid = 1, lsu_rdata = the selected half of mem_rdata, state returns to IDLE.
  - The latched lsu_addr[2] selects the half.
- IFU_BUSY:
  - mem_rvalid without ifu_icu_cancel: icu_ifu_data_valid_ic2 = 1, icu_ifu_data_ic2 = mem_rdata, state returns to IDLE.
  - mem_rvalid together with ifu_icu_cancel: data_valid is suppressed and the state returns to IDLE.
  - ifu_icu_cancel without mem_rvalid: state moves to DRAIN.
- DRAIN: on mem_rvalid, nothing is forwarded and the state returns to IDLE.
- The IFU re-request issued together with a cancel waits in IDLE and is arbitrated normally.
- ifu_icu_cancel asserted in IDLE or LSU_BUSY is ignored.
- mem_rvalid arriving in IDLE is ignored. This covers stale responses after a reset.
- starve_cnt (4-bit):
  - Increments when the LSU is acked while ifu_icu_req_ic1 = 1, saturating at LSU_STARVE_MAX.
  - Clears when the IFU is acked.
  - Holds otherwise.
- icu_ifu_data_ic2 and lsu_rdata are meaningful only in their valid cycle; when not valid they hold 0.

## Timing
- Reset values:
  - state = IDLE, starve_cnt = 0.
  - All acks, valids, mem_req, mem_wr and mem_wstrb are 0.
  - Data outputs are 0.
- Reset asserted mid-transaction forces IDLE on the next edge, with no response forwarded.
- Request to ack takes 0 cycles when mem_ack is already high. The response valid appears in the same cycle as mem_rvalid, with a combinational path from mem_rvalid.
- The minimum back-to-back gap is 1 IDLE cycle after each completion: a response in cycle N allows the next mem_req in cycle N+1.
- The latched owner fields (addr[2] and the owner's identity) are captured on the ack edge.
- Only one transaction is outstanding at any time.
  - mem_req is never asserted in BUSY or DRAIN.

## Test plan
- IFU only. Stimulus: fetch at 0x1c000000 with mem_ack = 1 and rvalid 3 cycles later carrying 0x0000002a_02c00000. Required response: ack in cycle 0, data_valid = 1 in cycle 3 with that data, next mem_req no earlier than cycle 4.
- Contention. Stimulus: lsu_req and ifu_req held continuously, each response returned 1 cycle after its ack. Required response: grant order LSU, LSU, LSU, IFU, LSU… with starve_cnt reaching 3, then clearing on the IFU grant.
- LSU store. Stimulus: addr 0x1c000104, wstrb 4'b0011, wdata 0xdeadbeef. Required response: mem_wstrb = 8'h30, mem_wdata = 0xdeadbeef_deadbeef, lsu_data_valid on rvalid.
- LSU load with addr[2] = 1 and mem_rdata = 0x11223344_55667788. Required response: lsu_rdata = 0x11223344.
- Cancel. Stimulus: IFU fetch acked, then cancel and a re-request at a new address 2 cycles before rvalid. Required response: the first rvalid is dropped (no data_valid), the state passes through DRAIN, and the re-request is issued the cycle after the drop and acked.
- Cancel coincident with rvalid produces no data_valid and the state returns to IDLE. Reset pulsed in LSU_BUSY: the later stale rvalid produces no lsu_data_valid.

Source files
------------

// File: rtl/cpu7_biu_arb.sv
// cpu7_biu_arb: shares a single 64-bit bus port between the IFU fetch path
// and the LSU. Only one transaction is in flight at a time. The LSU has
// priority, but after LSU_STARVE_MAX consecutive LSU grants made while the
// IFU is waiting, the IFU wins the next grant.
//
// Handshake semantics: a requester raises its req and holds it, together with
// its address and data fields, until it sees its ack. The ack is
// combinational from mem_ack in the same cycle that mem_req is presented. A
// response is signalled by a one-cycle data_valid pulse. That pulse is
// combinational from mem_rvalid while the owner's transaction is outstanding.
//
// o_dbg_state encoding: 0 = IDLE, 1 = IFU_BUSY, 2 = LSU_BUSY, 3 = DRAIN.
module cpu7_biu_arb #(
    parameter int LSU_STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifu_icu_req_ic1,
    input  logic [31:0] ifu_icu_addr_ic1,
    input  logic        ifu_icu_cancel,
    output logic        icu_ifu_ack_ic1,
    output logic [63:0] icu_ifu_data_ic2,
    output logic        icu_ifu_data_valid_ic2,
    input  logic        lsu_req,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    output logic        lsu_ack,
    output logic [31:0] lsu_rdata,
    output logic        lsu_data_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [1:0]  o_dbg_state,
    output logic [3:0]  o_dbg_starve_cnt
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_IFU_BUSY = 2'd1,
        S_LSU_BUSY = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    localparam logic [3:0] C_STARVE_MAX = 4'(LSU_STARVE_MAX);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_nxt;
    logic       r_lsu_hi;      // latched lsu_addr[2] of the outstanding LSU access
    logic       w_lsu_win;
    logic       w_ifu_win;

    // The LSU wins unless the IFU is waiting and has already been passed over
    // the maximum number of times.
    assign w_lsu_win = lsu_req && !(ifu_icu_req_ic1 && (r_starve_cnt == C_STARVE_MAX));
    assign w_ifu_win = !w_lsu_win && ifu_icu_req_ic1;

    assign o_dbg_state      = r_state;
    assign o_dbg_starve_cnt = r_starve_cnt;

    // Next-state, starvation counter and all outputs; reset gates everything to 0.
    always_comb begin
        w_state_nxt            = r_state;
        w_starve_nxt           = r_starve_cnt;
        icu_ifu_ack_ic1        = 1'b0;
        icu_ifu_data_ic2       = 64'h0;
        icu_ifu_data_valid_ic2 = 1'b0;
        lsu_ack                = 1'b0;
        lsu_rdata              = 32'h0;
        lsu_data_valid         = 1'b0;
        mem_req                = 1'b0;
        mem_addr               = 32'h0;
        mem_wr                 = 1'b0;
        mem_wdata              = 64'h0;
        mem_wstrb              = 8'h0;

        case (r_state)
            S_IDLE: begin
                if (w_lsu_win) begin
                    mem_req   = 1'b1;
                    mem_addr  = lsu_addr;
                    mem_wr    = lsu_wr;
                    mem_wdata = {lsu_wdata, lsu_wdata};
                    mem_wstrb = lsu_addr[2] ? {lsu_wstrb, 4'h0} : {4'h0, lsu_wstrb};
                    if (mem_ack) begin
                        lsu_ack     = 1'b1;
                        w_state_nxt = S_LSU_BUSY;
                        if (ifu_icu_req_ic1 && (r_starve_cnt != C_STARVE_MAX)) begin
                            w_starve_nxt = r_starve_cnt + 4'd1;
                        end
                    end
                end else if (w_ifu_win) begin
                    mem_req  = 1'b1;
                    mem_addr = ifu_icu_addr_ic1;
                    if (mem_ack) begin
                        icu_ifu_ack_ic1 = 1'b1;
                        w_state_nxt     = S_IFU_BUSY;
                        w_starve_nxt    = 4'd0;
                    end
                end
            end
            S_LSU_BUSY: begin
                if (mem_rvalid) begin
                    lsu_data_valid = 1'b1;
                    lsu_rdata      = r_lsu_hi ? mem_rdata[63:32] : mem_rdata[31:0];
                    w_state_nxt    = S_IDLE;
                end
            end
            S_IFU_BUSY: begin
                if (mem_rvalid) begin
                    if (!ifu_icu_cancel) begin
                        icu_ifu_data_valid_ic2 = 1'b1;
                        icu_ifu_data_ic2       = mem_rdata;
                    end
                    w_state_nxt = S_IDLE;
                end else if (ifu_icu_cancel) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The cancelled fetch's response is swallowed here.
                if (mem_rvalid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (reset) begin
            w_state_nxt            = S_IDLE;
            w_starve_nxt           = 4'd0;
            icu_ifu_ack_ic1        = 1'b0;
            icu_ifu_data_ic2       = 64'h0;
            icu_ifu_data_valid_ic2 = 1'b0;
            lsu_ack                = 1'b0;
            lsu_rdata              = 32'h0;
            lsu_data_valid         = 1'b0;
            mem_req                = 1'b0;
            mem_addr               = 32'h0;
            mem_wr                 = 1'b0;
            mem_wdata              = 64'h0;
            mem_wstrb              = 8'h0;
        end
    end

    // State register, starvation counter and the LSU half-select latched on ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= 4'd0;
            r_lsu_hi     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            if (lsu_ack) begin
                r_lsu_hi <= lsu_addr[2];
            end
        end
    end

endmodule

// File: tb/tb_cpu7_biu_arb.sv
// tb_cpu7_biu_arb: directed bench for cpu7_biu_arb. Stimulus pushes each
// expected ack or response into exp_q. A negedge monitor pops one entry for
// every ack or data_valid the DUT presents and compares the two.
module tb_cpu7_biu_arb;

  localparam int W = 107;  // {kind[1:0], addr[31:0], wstrb[7:0], wr, data[63:0]}
  localparam logic [1:0] K_IACK = 2'd0;
  localparam logic [1:0] K_LACK = 2'd1;
  localparam logic [1:0] K_IDAT = 2'd2;
  localparam logic [1:0] K_LDAT = 2'd3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_IFU  = 2'd1;
  localparam logic [1:0] ST_LSU  = 2'd2;
  localparam logic [1:0] ST_DRN  = 2'd3;

  logic        clk;
  logic        reset;
  logic        ifu_icu_req_ic1;
  logic [31:0] ifu_icu_addr_ic1;
  logic        ifu_icu_cancel;
  logic        icu_ifu_ack_ic1;
  logic [63:0] icu_ifu_data_ic2;
  logic        icu_ifu_data_valid_ic2;
  logic        lsu_req;
  logic [31:0] lsu_addr;
  logic        lsu_wr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_ack;
  logic [31:0] lsu_rdata;
  logic        lsu_data_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        mem_rvalid;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_starve_cnt;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  cpu7_biu_arb #(.LSU_STARVE_MAX(3)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .ifu_icu_req_ic1        (ifu_icu_req_ic1),
    .ifu_icu_addr_ic1       (ifu_icu_addr_ic1),
    .ifu_icu_cancel         (ifu_icu_cancel),
    .icu_ifu_ack_ic1        (icu_ifu_ack_ic1),
    .icu_ifu_data_ic2       (icu_ifu_data_ic2),
    .icu_ifu_data_valid_ic2 (icu_ifu_data_valid_ic2),
    .lsu_req                (lsu_req),
    .lsu_addr               (lsu_addr),
    .lsu_wr                 (lsu_wr),
    .lsu_wdata              (lsu_wdata),
    .lsu_wstrb              (lsu_wstrb),
    .lsu_ack                (lsu_ack),
    .lsu_rdata              (lsu_rdata),
    .lsu_data_valid         (lsu_data_valid),
    .mem_req                (mem_req),
    .mem_addr               (mem_addr),
    .mem_wr                 (mem_wr),
    .mem_wdata              (mem_wdata),
    .mem_wstrb              (mem_wstrb),
    .mem_ack                (mem_ack),
    .mem_rdata              (mem_rdata),
    .mem_rvalid             (mem_rvalid),
    .o_dbg_state            (dbg_state),
    .o_dbg_starve_cnt       (dbg_starve_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input logic [1:0] kind, input logic [31:0] addr,
                                      input logic [7:0] wstrb, input logic wr,
                                      input logic [63:0] data);
    mk = {kind, addr, wstrb, wr, data};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic sb_pop(input string name, input logic [W-1:0] obs);
    logic [W-1:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected output %h, nothing expected", name, obs);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", name, obs, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (icu_ifu_ack_ic1) sb_pop("ifu_ack", mk(K_IACK, mem_addr, mem_wstrb, mem_wr, 64'h0));
      if (lsu_ack)         sb_pop("lsu_ack", mk(K_LACK, mem_addr, mem_wstrb, mem_wr, mem_wdata));
      if (icu_ifu_data_valid_ic2)
        sb_pop("ifu_data", mk(K_IDAT, 32'h0, 8'h0, 1'b0, icu_ifu_data_ic2));
      if (lsu_data_valid)
        sb_pop("lsu_data", mk(K_LDAT, 32'h0, 8'h0, 1'b0, {32'h0, lsu_rdata}));
    end
  end

  // ---------------- stimulus ----------------
  int seq_lsu[5] = '{1, 1, 1, 0, 1};
  int seq_cnt[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1;
    ifu_icu_req_ic1 = 1'b1; ifu_icu_addr_ic1 = 32'h1c00_0000; ifu_icu_cancel = 1'b0;
    lsu_req = 1'b1; lsu_addr = 32'h1c00_0004; lsu_wr = 1'b1;
    lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hf;
    mem_ack = 1'b1; mem_rdata = 64'hffff_ffff_ffff_ffff; mem_rvalid = 1'b1;

    // Reset with everything active: all outputs must be held at 0.
    tick();
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_acks", {icu_ifu_ack_ic1, lsu_ack}, 0);
    chk("rst_valids", {icu_ifu_data_valid_ic2, lsu_data_valid}, 0);
    chk("rst_wr_wstrb", {mem_wr, mem_wstrb}, 0);
    chk("rst_data", icu_ifu_data_ic2 | {32'h0, lsu_rdata}, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_starve", dbg_starve_cnt, 0);
    tick();
    ifu_icu_req_ic1 = 1'b0; lsu_req = 1'b0; lsu_wr = 1'b0; lsu_wdata = 32'h0;
    lsu_wstrb = 4'h0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0;
    tick();
    reset = 1'b0;
    tick();

    // IFU only: ack in cycle 0, rvalid in cycle 3, next request granted in cycle 4.
    ifu_icu_req_ic1 = 1'b1; ifu_icu_addr_ic1 = 32'h1c00_0000; mem_ack = 1'b1;
    exp_q.push_back(mk(K_IACK, 32'h1c00_0000, 8'h0, 1'b0, 64'h0));
    @(negedge clk); chk("ifu_c0_mem_req", mem_req, 1);
    tick();
    ifu_icu_addr_ic1 = 32'h1c00_0008; mem_ack = 1'b0;
    @(negedge clk); chk("ifu_c1_no_req", mem_req, 0);
    tick();
    @(negedge clk); chk("ifu_c2_no_req", mem_req, 0); chk("ifu_c2_state", dbg_state, ST_IFU);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'h0000_002a_02c0_0000;
    exp_q.push_back(mk(K_IDAT, 32'h0, 8'h0, 1'b0, 64'h0000_002a_02c0_0000));
    @(negedge clk); chk("ifu_c3_no_req", mem_req, 0);
    tick();
    mem_rvalid = 1'b0; mem_rdata = 64'h0; mem_ack = 1'b1;
    exp_q.push_back(mk(K_IACK, 32'h1c00_0008, 8'h0, 1'b0, 64'h0));
    @(negedge clk); chk("ifu_c4_mem_req", mem_req, 1); chk("ifu_c4_addr", mem_addr, 32'h1c00_0008);
    tick();
    ifu_icu_req_ic1 = 1'b0; mem_ack = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h0123_4567_89ab_cdef;
    exp_q.push_back(mk(K_IDAT, 32'h0, 8'h0, 1'b0, 64'h0123_4567_89ab_cdef));
    tick();
    mem_rvalid = 1'b0; mem_rdata = 64'h0;
    tick();

    // Contention: grant order L, L, L, I, L with starve_cnt 0,1,2,3 then cleared.
    lsu_req = 1'b1; lsu_addr = 32'h1c00_0200; lsu_wr = 1'b0;
    ifu_icu_req_ic1 = 1'b1; ifu_icu_addr_ic1 = 32'h1c00_0040; mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_rvalid = 1'b0;
      if (seq_lsu[i] != 0) exp_q.push_back(mk(K_LACK, 32'h1c00_0200, 8'h0, 1'b0, 64'h0));
      else                 exp_q.push_back(mk(K_IACK, 32'h1c00_0040, 8'h0, 1'b0, 64'h0));
      @(negedge clk);
      chk($sformatf("cont_starve_%0d", i), dbg_starve_cnt, 64'(seq_cnt[i]));
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = {32'ha000_0000 + 32'(i), 32'hb000_0000 + 32'(i)};
      if (seq_lsu[i] != 0) exp_q.push_back(mk(K_LDAT, 32'h0, 8'h0, 1'b0, {32'h0, 32'hb000_0000 + 32'(i)}));
      else                 exp_q.push_back(mk(K_IDAT, 32'h0, 8'h0, 1'b0, mem_rdata));
      tick();
    end
    mem_rvalid = 1'b0; lsu_req = 1'b0; ifu_icu_req_ic1 = 1'b0; mem_ack = 1'b0;
    @(negedge clk); chk("cont_starve_end", dbg_starve_cnt, 1);
    tick();

    // LSU store to the upper word; first cycle with mem_ack low stays in IDLE.
    lsu_req = 1'b1; lsu_addr = 32'h1c00_0104; lsu_wr = 1'b1;
    lsu_wdata = 32'hdead_beef; lsu_wstrb = 4'b0011; mem_ack = 1'b0;
    @(negedge clk);
    chk("st_wait_req", mem_req, 1); chk("st_wait_ack", lsu_ack, 0);
    tick();
    chk("st_wait_state", dbg_state, ST_IDLE);
    mem_ack = 1'b1;
    exp_q.push_back(mk(K_LACK, 32'h1c00_0104, 8'h30, 1'b1, 64'hdead_beef_dead_beef));
    tick();
    lsu_req = 1'b0; mem_ack = 1'b0; lsu_wr = 1'b0; lsu_wdata = 32'h0; lsu_wstrb = 4'h0;
    mem_rvalid = 1'b1; mem_rdata = 64'h0;
    exp_q.push_back(mk(K_LDAT, 32'h0, 8'h0, 1'b0, 64'h0));
    tick();
    mem_rvalid = 1'b0;
    tick();

    // LSU load from the upper word.
    lsu_req = 1'b1; lsu_addr = 32'h1c00_0004; mem_ack = 1'b1;
    exp_q.push_back(mk(K_LACK, 32'h1c00_0004, 8'h0, 1'b0, 64'h0));
    tick();
    lsu_req = 1'b0; mem_ack = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
    exp_q.push_back(mk(K_LDAT, 32'h0, 8'h0, 1'b0, 64'h0000_0000_1122_3344));
    @(negedge clk); chk("ld_hi_rdata", lsu_rdata, 32'h1122_3344);
    tick();
    mem_rvalid = 1'b0;
    tick();

    // Cancel two cycles before rvalid with a re-request; response is drained.
    ifu_icu_req_ic1 = 1'b1; ifu_icu_addr_ic1 = 32'h1c00_1000; mem_ack = 1'b1;
    exp_q.push_back(mk(K_IACK, 32'h1c00_1000, 8'h0, 1'b0, 64'h0));
    tick();
    ifu_icu_req_ic1 = 1'b0; mem_ack = 1'b0;
    tick();
    ifu_icu_cancel = 1'b1; ifu_icu_req_ic1 = 1'b1; ifu_icu_addr_ic1 = 32'h1c00_2000;
    tick();
    ifu_icu_cancel = 1'b0;
    @(negedge clk); chk("cxl_drain_state", dbg_state, ST_DRN); chk("cxl_drain_no_req", mem_req, 0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'hbad0_bad0_bad0_bad0;
    @(negedge clk);
    chk("cxl_drop_valid", icu_ifu_data_valid_ic2, 0); chk("cxl_drop_data", icu_ifu_data_ic2, 0);
    tick();
    mem_rvalid = 1'b0; mem_rdata = 64'h0; mem_ack = 1'b1;
    exp_q.push_back(mk(K_IACK, 32'h1c00_2000, 8'h0, 1'b0, 64'h0));
    @(negedge clk); chk("cxl_rereq", mem_req, 1);
    tick();
    ifu_icu_req_ic1 = 1'b0; mem_ack = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h5555_6666_7777_8888;
    exp_q.push_back(mk(K_IDAT, 32'h0, 8'h0, 1'b0, 64'h5555_6666_7777_8888));
    tick();
    mem_rvalid = 1'b0;
    tick();

    // Cancel coincident with rvalid: no data_valid, back to IDLE.
    ifu_icu_req_ic1 = 1'b1; ifu_icu_addr_ic1 = 32'h1c00_3000; mem_ack = 1'b1;
    exp_q.push_back(mk(K_IACK, 32'h1c00_3000, 8'h0, 1'b0, 64'h0));
    tick();
    ifu_icu_req_ic1 = 1'b0; mem_ack = 1'b0;
    ifu_icu_cancel = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hcccc_cccc_cccc_cccc;
    @(negedge clk); chk("cxl_rv_valid", icu_ifu_data_valid_ic2, 0);
    tick();
    ifu_icu_cancel = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0;
    @(negedge clk); chk("cxl_rv_state", dbg_state, ST_IDLE);
    tick();

    // Reset pulsed in LSU_BUSY: the later stale rvalid is ignored.
    lsu_req = 1'b1; lsu_addr = 32'h1c00_0008; mem_ack = 1'b1;
    exp_q.push_back(mk(K_LACK, 32'h1c00_0008, 8'h0, 1'b0, 64'h0));
    tick();
    lsu_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk); chk("rstmid_busy", dbg_state, ST_LSU);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk); chk("rstmid_state", dbg_state, ST_IDLE);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'h9999_9999_9999_9999;
    @(negedge clk); chk("rstmid_stale", lsu_data_valid, 0);
    tick();
    mem_rvalid = 1'b0;
    tick();
    tick();

    chk("exp_q_empty", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
